// File: rtl/multi_alarm_clock_pkg.sv
// Shared widths, state encoding and time-of-day helpers for the multi-alarm clock.
package clock_pkg;

    localparam int HOURS_W   = 5;
    localparam int MIN_W     = 6;
    localparam int MAX_HOURS = 24;
    localparam int MAX_MIN   = 60;

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} ring_state_t;

    typedef struct packed {
        logic [HOURS_W-1:0] hours;
        logic [MIN_W-1:0]   minutes;
    } hm_t;

    function automatic logic [MIN_W-1:0] min_next(input logic [MIN_W-1:0] m);
        return (m == MIN_W'(MAX_MIN - 1)) ? '0 : m + 1'b1;
    endfunction

    function automatic logic [HOURS_W-1:0] hour_next(input logic [HOURS_W-1:0] h);
        return (h == HOURS_W'(MAX_HOURS - 1)) ? '0 : h + 1'b1;
    endfunction

    // Running clock: minute rollover carries into the hour.
    function automatic hm_t hm_tick(input hm_t t);
        hm_t r;
        r.minutes = min_next(t.minutes);
        r.hours   = (t.minutes == MIN_W'(MAX_MIN - 1)) ? hour_next(t.hours) : t.hours;
        return r;
    endfunction

    // Button edit: each field wraps on its own, no carry between them.
    function automatic hm_t hm_edit(input hm_t t, input logic min_inc, input logic hour_inc);
        hm_t r;
        r.minutes = min_inc  ? min_next(t.minutes) : t.minutes;
        r.hours   = hour_inc ? hour_next(t.hours)  : t.hours;
        return r;
    endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Control/status bundle between the clock core and its button/display/buzzer layers.
interface multi_alarm_clock_if #(
    parameter int NUM_ALARMS = 4
);
    import clock_pkg::*;

    localparam int SEL_W = $clog2(NUM_ALARMS + 1);
    localparam int ID_W  = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic                  set_en;
    logic [SEL_W-1:0]      sel;
    logic                  btn_min_inc;
    logic                  btn_hour_inc;
    logic [NUM_ALARMS-1:0] alarm_en;
    logic                  snooze;
    logic                  dismiss;
    logic [HOURS_W-1:0]    hours;
    logic [MIN_W-1:0]      minutes;
    logic [HOURS_W-1:0]    disp_hours;
    logic [MIN_W-1:0]      disp_minutes;
    logic                  ringing;
    logic [ID_W-1:0]       ring_id;
    logic                  snoozed;

    modport master (
        output set_en, sel, btn_min_inc, btn_hour_inc, alarm_en, snooze, dismiss,
        input  hours, minutes, disp_hours, disp_minutes, ringing, ring_id, snoozed
    );

    modport slave (
        input  set_en, sel, btn_min_inc, btn_hour_inc, alarm_en, snooze, dismiss,
        output hours, minutes, disp_hours, disp_minutes, ringing, ring_id, snoozed
    );

endinterface

// File: rtl/multi_alarm_clock_ring_fsm.sv
// IDLE/RING/SNOOZE alarm sequencer with a minute countdown for ring timeout and snooze.
// SNOOZE handling is compiled in only when MULTI_ALARM_SNOOZE_EN is defined.
module alarm_ring_fsm
    import clock_pkg::*;
#(
    parameter int ID_W       = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            match_valid,
    input  logic [ID_W-1:0] match_id,
    input  logic            minute_tick,
    input  logic            snooze,
    input  logic            dismiss,
    input  logic            armed,
    output logic            ringing,
    output logic            snoozed,
    output logic [ID_W-1:0] ring_id
);
    localparam int REM_W = 6;

    ring_state_t      state, state_next;
    logic [REM_W-1:0] rem, rem_next;
    logic [ID_W-1:0]  id_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= '0;
            ring_id <= '0;
        end else begin
            state   <= state_next;
            rem     <= rem_next;
            ring_id <= id_next;
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = rem;
        id_next    = ring_id;
        case (state)
            IDLE: begin
                if (match_valid) begin
                    state_next = RING;
                    rem_next   = REM_W'(RING_MIN);
                    id_next    = match_id;
                end
            end
            RING: begin
                if (dismiss || !armed) begin
                    state_next = IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_next = SNOOZE;
                    rem_next   = REM_W'(SNOOZE_MIN);
`endif
                end else if (minute_tick) begin
                    rem_next = rem - 1'b1;
                    if (rem == REM_W'(1)) state_next = IDLE;
                end
            end
`ifdef MULTI_ALARM_SNOOZE_EN
            SNOOZE: begin
                if (dismiss || !armed) begin
                    state_next = IDLE;
                end else if (minute_tick) begin
                    rem_next = rem - 1'b1;
                    if (rem == REM_W'(1)) begin
                        state_next = RING;
                        rem_next   = REM_W'(RING_MIN);
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign ringing = (state == RING);

`ifdef MULTI_ALARM_SNOOZE_EN
    assign snoozed = (state == SNOOZE);
`else
    logic snooze_unused;
    assign snooze_unused = snooze;
    assign snoozed       = 1'b0;
`endif

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour clock core with NUM_ALARMS button-programmable alarms and a ring sequencer.
// Define MULTI_ALARM_SNOOZE_EN to enable the snooze input and SNOOZE state.
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter int TICK_COUNT_MAX = 10000000,
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_MIN       = 10
) (
    input logic                clk,
    input logic                rst,
    multi_alarm_clock_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_ALARMS + 1);
    localparam int ID_W  = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int CNT_W = $clog2(TICK_COUNT_MAX);

    logic [CNT_W-1:0] presc;
    logic             time_set;
    logic             alarm_set;
    logic             minute_tick;
    logic             tick_d;
    hm_t              now;
    hm_t              alarms [NUM_ALARMS];
    hm_t              disp;
    logic             match_valid;
    logic [ID_W-1:0]  match_id;
    logic [ID_W-1:0]  ring_id;

    assign time_set    = bus.set_en && (bus.sel == '0);
    assign alarm_set   = bus.set_en && (bus.sel != '0) && (bus.sel <= SEL_W'(NUM_ALARMS));
    assign minute_tick = !time_set && (presc == CNT_W'(TICK_COUNT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            tick_d <= 1'b0;
            now    <= '0;
        end else begin
            tick_d <= minute_tick;
            if (time_set) begin
                presc <= '0;
                now   <= hm_edit(now, bus.btn_min_inc, bus.btn_hour_inc);
            end else begin
                presc <= minute_tick ? '0 : presc + 1'b1;
                if (minute_tick) now <= hm_tick(now);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++) alarms[i] <= '0;
        end else if (alarm_set) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                if (bus.sel == SEL_W'(i + 1))
                    alarms[i] <= hm_edit(alarms[i], bus.btn_min_inc, bus.btn_hour_inc);
            end
        end
    end

    // tick_d gates the compare so button edits that land on an alarm time never ring.
    always_comb begin
        match_valid = 1'b0;
        match_id    = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (!match_valid && tick_d && bus.alarm_en[i] && (alarms[i] == now)) begin
                match_valid = 1'b1;
                match_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        disp = now;
        if (alarm_set) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                if (bus.sel == SEL_W'(i + 1)) disp = alarms[i];
            end
        end
    end

    alarm_ring_fsm #(
        .ID_W       (ID_W),
        .SNOOZE_MIN (SNOOZE_MIN),
        .RING_MIN   (RING_MIN)
    ) u_ring_fsm (
        .clk         (clk),
        .rst         (rst),
        .match_valid (match_valid),
        .match_id    (match_id),
        .minute_tick (minute_tick),
        .snooze      (bus.snooze),
        .dismiss     (bus.dismiss),
        .armed       (bus.alarm_en[ring_id]),
        .ringing     (bus.ringing),
        .snoozed     (bus.snoozed),
        .ring_id     (ring_id)
    );

    assign bus.ring_id      = ring_id;
    assign bus.hours        = now.hours;
    assign bus.minutes      = now.minutes;
    assign bus.disp_hours   = disp.hours;
    assign bus.disp_minutes = disp.minutes;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with a 4-cycle minute, RING_MIN=2, SNOOZE_MIN=5.
`timescale 1ns/1ps
module tb_multi_alarm_clock;

    localparam int TICKS = 4;
    localparam int NA    = 4;
    localparam int SNZ   = 5;
    localparam int RNG   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    multi_alarm_clock_if #(.NUM_ALARMS(NA)) bus ();

    multi_alarm_clock #(
        .TICK_COUNT_MAX (TICKS),
        .NUM_ALARMS     (NA),
        .SNOOZE_MIN     (SNZ),
        .RING_MIN       (RNG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.set_en       = 1'b0;
        bus.sel          = '0;
        bus.btn_min_inc  = 1'b0;
        bus.btn_hour_inc = 1'b0;
        bus.alarm_en     = '0;
        bus.snooze       = 1'b0;
        bus.dismiss      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic press(input logic m, input logic h, input int n);
        bus.btn_min_inc  = m;
        bus.btn_hour_inc = h;
        step(n);
        bus.btn_min_inc  = 1'b0;
        bus.btn_hour_inc = 1'b0;
    endtask

    // Program alarm idx to 00:m right after reset and stop on the cycle it starts ringing.
    task automatic ring_setup(input int idx, input int m);
        bus.set_en   = 1'b1;
        bus.sel      = 3'(idx + 1);
        bus.alarm_en = 4'(1 << idx);
        press(1'b1, 1'b0, m);
        bus.set_en = 1'b0;
        bus.sel    = '0;
        step(3 * m + 1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({bus.hours, bus.minutes} !== 11'd0) begin errors++; $display("FAIL reset_time: got %0d:%0d expected 0:0", bus.hours, bus.minutes); end
        checks++; if (bus.ringing !== 1'b0 || bus.snoozed !== 1'b0) begin errors++; $display("FAIL reset_flags: got ringing=%b snoozed=%b expected 0 0", bus.ringing, bus.snoozed); end
        checks++; if (bus.ring_id !== 2'd0) begin errors++; $display("FAIL reset_ring_id: got %0d expected 0", bus.ring_id); end
        checks++; if ({bus.disp_hours, bus.disp_minutes} !== 11'd0) begin errors++; $display("FAIL reset_disp: got %0d:%0d expected 0:0", bus.disp_hours, bus.disp_minutes); end
    endtask

    task automatic test_timekeeping();
        do_reset();
        step(239);
        checks++; if ({bus.hours, bus.minutes} !== {5'd0, 6'd59}) begin errors++; $display("FAIL run_0059: got %0d:%0d expected 0:59", bus.hours, bus.minutes); end
        step(1);
        checks++; if ({bus.hours, bus.minutes} !== {5'd1, 6'd0}) begin errors++; $display("FAIL run_0100: got %0d:%0d expected 1:0", bus.hours, bus.minutes); end
        do_reset();
        bus.set_en = 1'b1;
        press(1'b1, 1'b1, 23);
        checks++; if ({bus.disp_hours, bus.disp_minutes} !== {5'd23, 6'd23}) begin errors++; $display("FAIL set_both: got %0d:%0d expected 23:23", bus.disp_hours, bus.disp_minutes); end
        press(1'b1, 1'b0, 36);
        step(8);
        checks++; if ({bus.hours, bus.minutes} !== {5'd23, 6'd59}) begin errors++; $display("FAIL set_hold: got %0d:%0d expected 23:59", bus.hours, bus.minutes); end
        bus.set_en = 1'b0;
        step(3);
        checks++; if ({bus.hours, bus.minutes} !== {5'd23, 6'd59}) begin errors++; $display("FAIL pre_wrap: got %0d:%0d expected 23:59", bus.hours, bus.minutes); end
        step(1);
        checks++; if ({bus.hours, bus.minutes} !== 11'd0) begin errors++; $display("FAIL day_wrap: got %0d:%0d expected 0:0", bus.hours, bus.minutes); end
    endtask

    task automatic test_set_limits();
        do_reset();
        bus.set_en = 1'b1;
        press(1'b1, 1'b0, 59);
        checks++; if ({bus.hours, bus.minutes} !== {5'd0, 6'd59}) begin errors++; $display("FAIL min_59: got %0d:%0d expected 0:59", bus.hours, bus.minutes); end
        press(1'b1, 1'b0, 1);
        checks++; if ({bus.hours, bus.minutes} !== 11'd0) begin errors++; $display("FAIL min_wrap_nocarry: got %0d:%0d expected 0:0", bus.hours, bus.minutes); end
        press(1'b0, 1'b1, 23);
        checks++; if ({bus.hours, bus.minutes} !== {5'd23, 6'd0}) begin errors++; $display("FAIL hour_23: got %0d:%0d expected 23:0", bus.hours, bus.minutes); end
        press(1'b0, 1'b1, 1);
        checks++; if ({bus.hours, bus.minutes} !== 11'd0) begin errors++; $display("FAIL hour_wrap: got %0d:%0d expected 0:0", bus.hours, bus.minutes); end
        do_reset();
        bus.set_en = 1'b1;
        bus.sel    = 3'd1;
        press(1'b0, 1'b1, 3);
        checks++; if ({bus.disp_hours, bus.disp_minutes} !== {5'd3, 6'd0}) begin errors++; $display("FAIL alarm_disp: got %0d:%0d expected 3:0", bus.disp_hours, bus.disp_minutes); end
        bus.sel = 3'd5;
        press(1'b1, 1'b1, 1);
        checks++; if ({bus.disp_hours, bus.disp_minutes} !== {5'd0, 6'd1}) begin errors++; $display("FAIL sel_oob_disp: got %0d:%0d expected 0:1", bus.disp_hours, bus.disp_minutes); end
        bus.sel = 3'd1;
        #1;
        checks++; if ({bus.disp_hours, bus.disp_minutes} !== {5'd3, 6'd0}) begin errors++; $display("FAIL sel_oob_ignored: got %0d:%0d expected 3:0", bus.disp_hours, bus.disp_minutes); end
        bus.sel = 3'd2;
        #1;
        checks++; if ({bus.disp_hours, bus.disp_minutes} !== 11'd0) begin errors++; $display("FAIL alarm1_untouched: got %0d:%0d expected 0:0", bus.disp_hours, bus.disp_minutes); end
    endtask

    task automatic test_ring_basic();
        do_reset();
        bus.set_en = 1'b1;
        bus.sel    = 3'd1;
        press(1'b0, 1'b1, 8);
        checks++; if ({bus.disp_hours, bus.disp_minutes} !== {5'd8, 6'd0}) begin errors++; $display("FAIL alarm0_0800: got %0d:%0d expected 8:0", bus.disp_hours, bus.disp_minutes); end
        bus.sel = 3'd0;
        #1;
        checks++; if ({bus.disp_hours, bus.disp_minutes} !== {5'd0, 6'd2}) begin errors++; $display("FAIL time_during_alarm_set: got %0d:%0d expected 0:2", bus.disp_hours, bus.disp_minutes); end
        press(1'b1, 1'b1, 7);
        press(1'b1, 1'b0, 50);
        checks++; if ({bus.hours, bus.minutes} !== {5'd7, 6'd59}) begin errors++; $display("FAIL time_0759: got %0d:%0d expected 7:59", bus.hours, bus.minutes); end
        bus.alarm_en = 4'b0001;
        bus.set_en   = 1'b0;
        step(4);
        checks++; if ({bus.hours, bus.minutes, bus.ringing} !== {5'd8, 6'd0, 1'b0}) begin errors++; $display("FAIL tick_0800: got %0d:%0d ringing=%b expected 8:0 ringing=0", bus.hours, bus.minutes, bus.ringing); end
        step(1);
        checks++; if ({bus.ringing, bus.ring_id} !== {1'b1, 2'd0}) begin errors++; $display("FAIL ring_a0: got ringing=%b id=%0d expected 1 0", bus.ringing, bus.ring_id); end
        bus.dismiss = 1'b1;
        step(1);
        bus.dismiss = 1'b0;
        checks++; if ({bus.ringing, bus.ring_id} !== {1'b0, 2'd0}) begin errors++; $display("FAIL dismiss: got ringing=%b id=%0d expected 0 0", bus.ringing, bus.ring_id); end
    endtask

    task automatic test_priority();
        do_reset();
        bus.set_en = 1'b1;
        bus.sel    = 3'd2;
        press(1'b0, 1'b1, 8);
        bus.sel = 3'd4;
        press(1'b0, 1'b1, 8);
        bus.sel = 3'd0;
        press(1'b1, 1'b1, 7);
        press(1'b1, 1'b0, 48);
        bus.alarm_en = 4'b1010;
        bus.set_en   = 1'b0;
        step(5);
        checks++; if ({bus.ringing, bus.ring_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL priority: got ringing=%b id=%0d expected 1 1", bus.ringing, bus.ring_id); end
        bus.dismiss = 1'b1;
        step(1);
        bus.dismiss = 1'b0;
        checks++; if ({bus.ringing, bus.ring_id} !== {1'b0, 2'd1}) begin errors++; $display("FAIL id_hold: got ringing=%b id=%0d expected 0 1", bus.ringing, bus.ring_id); end
        bus.set_en = 1'b1;
        press(1'b0, 1'b1, 23);
        checks++; if ({bus.hours, bus.minutes} !== {5'd7, 6'd0}) begin errors++; $display("FAIL set_0700: got %0d:%0d expected 7:0", bus.hours, bus.minutes); end
        press(1'b0, 1'b1, 1);
        step(2);
        checks++; if ({bus.hours, bus.minutes, bus.ringing} !== {5'd8, 6'd0, 1'b0}) begin errors++; $display("FAIL button_no_ring: got %0d:%0d ringing=%b expected 8:0 ringing=0", bus.hours, bus.minutes, bus.ringing); end
        bus.set_en = 1'b0;
        step(6);
        checks++; if ({bus.hours, bus.minutes, bus.ringing} !== {5'd8, 6'd1, 1'b0}) begin errors++; $display("FAIL after_button: got %0d:%0d ringing=%b expected 8:1 ringing=0", bus.hours, bus.minutes, bus.ringing); end
    endtask

    task automatic test_timeout();
        do_reset();
        ring_setup(0, 3);
        checks++; if ({bus.ringing, bus.ring_id} !== {1'b1, 2'd0}) begin errors++; $display("FAIL timeout_start: got ringing=%b id=%0d expected 1 0", bus.ringing, bus.ring_id); end
        step(6);
        checks++; if (bus.ringing !== 1'b1) begin errors++; $display("FAIL timeout_early: got ringing=%b expected 1", bus.ringing); end
        step(1);
        checks++; if (bus.ringing !== 1'b0) begin errors++; $display("FAIL timeout_end: got ringing=%b expected 0", bus.ringing); end
    endtask

    task automatic test_disarm();
        do_reset();
        ring_setup(1, 3);
        checks++; if ({bus.ringing, bus.ring_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL disarm_start: got ringing=%b id=%0d expected 1 1", bus.ringing, bus.ring_id); end
        bus.alarm_en = 4'b0000;
        step(1);
        checks++; if ({bus.ringing, bus.ring_id} !== {1'b0, 2'd1}) begin errors++; $display("FAIL disarm: got ringing=%b id=%0d expected 0 1", bus.ringing, bus.ring_id); end
    endtask

`ifdef MULTI_ALARM_SNOOZE_EN
    task automatic test_snooze();
        do_reset();
        ring_setup(0, 3);
        bus.snooze = 1'b1;
        step(1);
        bus.snooze = 1'b0;
        checks++; if ({bus.ringing, bus.snoozed} !== 2'b01) begin errors++; $display("FAIL snooze_enter: got ringing=%b snoozed=%b expected 0 1", bus.ringing, bus.snoozed); end
        step(17);
        checks++; if ({bus.ringing, bus.snoozed} !== 2'b01) begin errors++; $display("FAIL snooze_hold: got ringing=%b snoozed=%b expected 0 1", bus.ringing, bus.snoozed); end
        step(1);
        checks++; if ({bus.ringing, bus.snoozed} !== 2'b10) begin errors++; $display("FAIL snooze_rering: got ringing=%b snoozed=%b expected 1 0", bus.ringing, bus.snoozed); end
        bus.snooze  = 1'b1;
        bus.dismiss = 1'b1;
        step(1);
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b0;
        checks++; if ({bus.ringing, bus.snoozed} !== 2'b00) begin errors++; $display("FAIL dismiss_wins: got ringing=%b snoozed=%b expected 0 0", bus.ringing, bus.snoozed); end
    endtask
`else
    task automatic test_snooze();
        do_reset();
        ring_setup(0, 3);
        bus.snooze = 1'b1;
        step(1);
        bus.snooze = 1'b0;
        checks++; if ({bus.ringing, bus.snoozed} !== 2'b10) begin errors++; $display("FAIL snooze_ignored: got ringing=%b snoozed=%b expected 1 0", bus.ringing, bus.snoozed); end
    endtask
`endif

    task automatic test_reset_mid_ring();
        do_reset();
        ring_setup(2, 3);
        checks++; if ({bus.ringing, bus.ring_id} !== {1'b1, 2'd2}) begin errors++; $display("FAIL pre_rst_ring: got ringing=%b id=%0d expected 1 2", bus.ringing, bus.ring_id); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if ({bus.ringing, bus.snoozed, bus.ring_id} !== 4'b0000) begin errors++; $display("FAIL rst_ring: got ringing=%b snoozed=%b id=%0d expected 0 0 0", bus.ringing, bus.snoozed, bus.ring_id); end
        checks++; if ({bus.hours, bus.minutes} !== 11'd0) begin errors++; $display("FAIL rst_time: got %0d:%0d expected 0:0", bus.hours, bus.minutes); end
        bus.set_en = 1'b1;
        bus.sel    = 3'd3;
        #1;
        checks++; if ({bus.disp_hours, bus.disp_minutes} !== 11'd0) begin errors++; $display("FAIL rst_alarm_lost: got %0d:%0d expected 0:0", bus.disp_hours, bus.disp_minutes); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_timekeeping();
        test_set_limits();
        test_ring_basic();
        test_priority();
        test_timeout();
        test_disarm();
        test_snooze();
        test_reset_mid_ring();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised 24-hour clock core with NUM_ALARMS independently programmable alarms, in-place time/alarm setting via increment buttons, and a ring state machine with snooze and auto-timeout. It replaces the single-alarm clock top: the display/7-segment layer consumes `disp_hours`/`disp_minutes`, and the buzzer driver consumes `ringing`. Buttons are single-cycle pulses from the debouncer layer.

## Interface
- `TICK_COUNT_MAX`, 10000000: clk cycles per clock minute (≥2).
- `NUM_ALARMS`, 4: alarm channels (1..8).
- `SNOOZE_MIN`, 5: snooze length in clock minutes (1..59).
- `RING_MIN`, 10: ring auto-timeout in clock minutes (1..59).

- `clk` in 1: system clock, one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `set_en` in 1: setting mode enable.
- `sel` in $clog2(NUM_ALARMS+1): 0 = time, k = alarm k-1.
- `btn_min_inc` in 1: pulse, +1 minute of selected target.
- `btn_hour_inc` in 1: pulse, +1 hour of selected target.
- `alarm_en` in NUM_ALARMS: per-alarm arm bits.
- `snooze` in 1: pulse, snooze ringing alarm.
- `dismiss` in 1: pulse, stop ringing/snoozed alarm.
- `hours` out 5: current hour 0..23.
- `minutes` out 6: current minute 0..59.
- `disp_hours` out 5: hour of target selected by `sel` when `set_en`, else `hours`.
- `disp_minutes` out 6: minute likewise.
- `ringing` out 1: alarm sounding.
- `ring_id` out $clog2(NUM_ALARMS) (min 1): index of alarm that triggered.
- `snoozed` out 1: in snooze.

## Operation
- Reset: prescaler 0, time 00:00, all alarm registers 00:00, FSM IDLE; `ringing`=0, `snoozed`=0, `ring_id`=0.
- Prescaler counts 0..TICK_COUNT_MAX-1; `minute_tick` internal, high when count = TICK_COUNT_MAX-1.
- Tick: minutes +1; 59→0 carries hours +1; 23:59→00:00.
- Time setting (`set_en`=1, `sel`=0): prescaler held at 0, ticks suppressed. `btn_min_inc`: minutes +1, 59→0 with no hour carry. `btn_hour_inc`: 23→0. Both same cycle: both applied.
- Alarm setting (`set_en`=1, `sel`=k≥1): same button rules applied to alarm k-1; time keeps running. `sel` > NUM_ALARMS: buttons ignored, display shows time.
- Match: evaluated only on the cycle after a real `minute_tick` (never after button edits); alarm i matches if `alarm_en[i]` and alarm i == new time. Lowest matching index wins.
- FSM states IDLE, RING, SNOOZE; minute counter `rem` (6 bits).
  - IDLE + match → RING, `ring_id`=index, `rem`=RING_MIN.
  - RING: each tick `rem`-1; `rem` reaching 0 → IDLE. `dismiss` → IDLE. `snooze` → SNOOZE, `rem`=SNOOZE_MIN.
  - SNOOZE: each tick `rem`-1; reaching 0 → RING, `rem`=RING_MIN. `dismiss` → IDLE.
  - `dismiss` and `snooze` same cycle: dismiss wins.
  - Matches while RING/SNOOZE are discarded.
  - Clearing `alarm_en[ring_id]` while RING/SNOOZE → IDLE next cycle.
- `ringing` = (state==RING); `snoozed` = (state==SNOOZE); `ring_id` holds last value in IDLE.

## Timing
- Tick at cycle T: `hours`/`minutes` new at T+1; match registered at T+1; `ringing` high at T+2.
- Button pulse at cycle T: target register and `disp_*` updated at T+1.
- `snooze`/`dismiss` at T: state change visible at T+1.
- All outputs registered except `disp_*` (combinational mux of registers).
- `rst` mid-ring: IDLE at next edge; alarm settings lost.

## Configuration
- `MULTI_ALARM_SNOOZE_EN` defined: SNOOZE state, `snooze` input and `snoozed` output behave as above.
- Not defined: SNOOZE state absent, `snooze` ignored, `snoozed` tied 0; RING exits only via timeout, `dismiss`, or disarm.

## Structure
- Package `clock_pkg`: `HOURS_W`=5, `MIN_W`=6, `MAX_HOURS`=24, `MAX_MIN`=60, `ring_state_t` enum {IDLE, RING, SNOOZE}, `hm_t` struct {hours, minutes}.
- Sub-module `alarm_ring_fsm`: IDLE/RING/SNOOZE FSM with `rem` counter. Inputs: `match_valid`, `match_id`, `minute_tick`, `snooze`, `dismiss`, `armed`.
- Time counter, alarm register array, and compare logic live in the top module.

## Test plan
- TICK_COUNT_MAX=4: after reset, 240 cycles → 01:00; 23:59 + one tick → 00:00.
- Set time 07:59 via buttons (sel=0), alarm 0 = 08:00, `alarm_en`=0001, release `set_en` → `ringing`=1 and `ring_id`=0 two cycles after the tick.
- Alarms 1 and 3 both 08:00 and armed → `ring_id`=1. Set time to 08:00 by button → no ring.
- RING, `snooze` → `snoozed`=1; after 5 ticks `ringing`=1 again; `dismiss`+`snooze` same cycle → IDLE.
- RING_MIN=2, no input → `ringing` drops after 2 ticks. Clear `alarm_en[0]` mid-ring → IDLE next cycle.
- Macro undefined: `snooze` during RING → stays RING, `snoozed`=0. `rst` mid-ring → all outputs at reset values next cycle.
